fsm_divider: RTL and testbench
==============================

# fsm_divider

Sequential 16-by-8 unsigned restoring divider with an `init`/`finished` handshake. It is the inverse counterpart of the team's shift-add multiplier FSM: the same start/done protocol and the same clocking, but it takes a 16-bit dividend and an 8-bit divisor. It produces one quotient bit per clock and returns a 16-bit quotient and an 8-bit remainder. It sits beside the multiplier in the datapath, so a product can be divided back by either operand.

## Interface
- `DIVIDEND_W`, default 16: dividend and quotient width.
- `DIVISOR_W`, default 8: divisor and remainder width.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; forces IDLE and clears all outputs.
- `init`, in, 1: start request; level-sampled in IDLE.
- `dividend`, in, 16: numerator, captured at start.
- `divisor`, in, 8: denominator, captured at start.
- `finished`, out, 1: high while in DONE.
- `quotient`, out, 16: result of the last completed division.
- `remainder`, out, 8: remainder of the last completed division.
- `div_by_zero`, out, 1: last completed division had divisor 0.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `init`=1 at an edge: capture `dividend` into the shift register `dq`, `divisor` into `dv`, clear the partial remainder `pr` (8 bits) and the step counter `cnt` (5 bits).
  - If the divisor is nonzero, go to CALC.
  - If the divisor is 0, go directly to DONE.
- **CALC step** (one per edge):
  - `t = {pr, dq[15]}` (9 bits); `dq <<= 1`.
  - If `t >= {1'b0, dv}`: `pr = t - dv` (fits 8 bits) and `dq[0] = 1`.
  - Otherwise: `pr = t[7:0]` and `dq[0] = 0`.
  - `cnt++`.
- **CALC to DONE**: on the step with `cnt`=15, i.e. after 16 steps. On that edge, `quotient<=dq_next`, `remainder<=pr_next`, `div_by_zero<=0`.
- **Divide-by-zero**: on the IDLE-to-DONE edge, `quotient<=16'hFFFF`, `remainder<=dividend[7:0]`, `div_by_zero<=1`.
- **DONE**
  - `finished`=1.
  - Stays in DONE while `init`=1; no automatic restart.
  - Goes to IDLE on the first edge with `init`=0.
- **Hold behaviour**
  - `quotient`, `remainder` and `div_by_zero` hold their values outside the update edges.
  - They keep the previous result through IDLE and CALC of the next operation.
- **Ignored inputs during CALC**
  - `init` is ignored; deasserting it does not abort the operation.
  - Changes to `dividend`/`divisor` are ignored; operands are latched.
- **Reset**: asserted at any time, including mid-CALC:
  - Immediately forces IDLE.
  - Clears `finished`, `quotient`, `remainder`, `div_by_zero`, `dq`, `pr`, `cnt` to 0.
  - No partial result is ever presented.

## Timing
- Reset values: `finished`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE.
- **Nonzero divisor**
  - Edge E0 samples `init` in IDLE.
  - Edges E1..E16 perform steps.
  - `finished` and the results are valid after E16; latency is 16 cycles after the start edge.
- **Zero divisor**: `finished` and the results are valid after E0.
- Minimum spacing between operations: `init` low for at least one edge in DONE, then high again in IDLE. That is 18 edges start-to-start for the nonzero case.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `fsm_divider_pkg` holds:
  - State encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2; encoding 3 decodes to IDLE).
  - Width constants `DIVIDEND_W`/`DIVISOR_W`.
  - `STEPS` = `DIVIDEND_W`.
- One sub-module, `div_step`: purely combinational single restoring step.
  - Inputs: `pr`, `dq`, `dv`.
  - Outputs: `pr_next`, `dq_next`.
- The top level holds the FSM, counter and output registers.

## Test plan
- 45 / 3 (`dividend`=16'h002D, `divisor`=8'h03), `init` pulsed:
  - `finished` rises after E16.
  - `quotient`=16'h000F, `remainder`=8'h00, `div_by_zero`=0.
- 1000 / 7 (16'h03E8 / 8'h07):
  - `quotient`=16'h008E, `remainder`=8'h06.
  - Outputs hold the previous result until E16.
- Boundary operands:
  - 16'hFFFF / 8'hFF: `quotient`=16'h0101, `remainder`=0.
  - 5 / 9: `quotient`=0, `remainder`=5.
- 16'h1234 / 0:
  - `finished`=1 after E0.
  - `quotient`=16'hFFFF, `remainder`=8'h34, `div_by_zero`=1.
- Handshake: `init` held high through DONE for 5 edges.
  - `finished` stays 1 and the results are stable.
  - Drop `init`: IDLE and `finished`=0 after the next edge.
  - Operand changes during CALC do not affect the result.
- Reset mid-CALC after 8 steps: all outputs 0 immediately, without waiting for an edge.
  - A following 1000 / 7 returns 16'h008E / 8'h06.

Source files
------------

// File: rtl/fsm_divider_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package fsm_divider_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int STEPS      = DIVIDEND_W;

    // Encoding 2'd3 is unused and is steered back to IDLE by the FSM default arm.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fsm_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and shift the resulting quotient bit into dq.
module div_step #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic [DIVISOR_W-1:0]  pr,
    input  logic [DIVIDEND_W-1:0] dq,
    input  logic [DIVISOR_W-1:0]  dv,
    output logic [DIVISOR_W-1:0]  pr_next,
    output logic [DIVIDEND_W-1:0] dq_next
);

    logic [DIVISOR_W:0] t;
    logic [DIVISOR_W:0] diff;
    logic               ge;

    // Trial subtraction is one bit wider than the divisor; when t >= dv the
    // difference is strictly below dv, so it always fits back into pr.
    always_comb begin
        t       = {pr, dq[DIVIDEND_W-1]};
        ge      = (t >= {1'b0, dv});
        diff    = t - {1'b0, dv};
        pr_next = ge ? diff[DIVISOR_W-1:0] : t[DIVISOR_W-1:0];
        dq_next = {dq[DIVIDEND_W-2:0], ge};
    end

endmodule

// File: rtl/fsm_divider.sv
// 16-by-8 unsigned restoring divider, one quotient bit per clock, with an
// init/finished handshake matching the shift-add multiplier.
module fsm_divider
    import fsm_divider_pkg::*;
#(
    parameter int DIVIDEND_W = fsm_divider_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = fsm_divider_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  finished,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    state_t                state;
    logic [DIVIDEND_W-1:0] dq;
    logic [DIVISOR_W-1:0]  dv;
    logic [DIVISOR_W-1:0]  pr;
    logic [CNT_W-1:0]      cnt;
    logic [DIVISOR_W-1:0]  pr_next;
    logic [DIVIDEND_W-1:0] dq_next;

    div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_step (
        .pr      (pr),
        .dq      (dq),
        .dv      (dv),
        .pr_next (pr_next),
        .dq_next (dq_next)
    );

    // Control FSM, datapath registers and result registers; results only move
    // on the final CALC edge or the divide-by-zero shortcut edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dq          <= '0;
            dv          <= '0;
            pr          <= '0;
            cnt         <= '0;
            finished    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        dq  <= dividend;
                        dv  <= divisor;
                        pr  <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            finished    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    dq  <= dq_next;
                    pr  <= pr_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        finished    <= 1'b1;
                        quotient    <= dq_next;
                        remainder   <= pr_next;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    // Holding init high parks here; a new start needs init low first.
                    if (!init) begin
                        state    <= IDLE;
                        finished <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_divider.sv
// Directed bench for fsm_divider: vector table plus handshake/reset sequences.
module tb_fsm_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        finished;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    fsm_divider dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .dividend    (dividend),
        .divisor     (divisor),
        .finished    (finished),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Pulse init for one edge, then count edges until finished (bounded).
    task automatic run_vec(input vec_t v, input logic [15:0] prev_q, input string tag);
        int lat;
        @(negedge clk);
        dividend = v.dd;
        divisor  = v.dv;
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        lat  = 0;
        while (!finished && lat < 40) begin
            if (lat == 15) chk({tag, " hold_prev_q"}, quotient, prev_q);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " quotient"}, quotient, v.q);
        chk({tag, " remainder"}, remainder, v.r);
        chk({tag, " div_by_zero"}, div_by_zero, v.dz);
        @(negedge clk);
        chk({tag, " finished_drop"}, finished, 1'b0);
    endtask

    initial begin
        logic [15:0] prev;
        vecs[0] = '{16'h002D, 8'h03, 16'h000F, 8'h00, 1'b0, 16};
        vecs[1] = '{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16};
        vecs[2] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16};
        vecs[3] = '{16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 16};
        vecs[4] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 0};
        vecs[5] = '{16'h8000, 8'h02, 16'h4000, 8'h00, 1'b0, 16};

        reset = 1'b1; init = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset finished", finished, 1'b0);
        chk("reset quotient", quotient, 16'h0);
        chk("reset remainder", remainder, 8'h0);
        chk("reset div_by_zero", div_by_zero, 1'b0);
        reset = 1'b0;

        prev = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], prev, $sformatf("vec%0d", i));
            prev = vecs[i].q;
        end

        // init held through CALC and DONE; operands change mid-CALC.
        @(negedge clk);
        dividend = 16'h03E8; divisor = 8'h07; init = 1'b1;
        @(negedge clk);
        dividend = 16'hFFFF; divisor = 8'h01;
        begin
            int n = 0;
            while (!finished && n < 40) begin @(negedge clk); n++; end
            chk("hs latency", n, 16);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hs finished_held%0d", k), finished, 1'b1);
            chk($sformatf("hs quotient_held%0d", k), quotient, 16'h008E);
            chk($sformatf("hs remainder_held%0d", k), remainder, 8'h06);
        end
        init = 1'b0;
        @(negedge clk);
        chk("hs finished_drop", finished, 1'b0);
        @(negedge clk);
        chk("hs no_restart", finished, 1'b0);

        // Reset mid-CALC after 8 steps, asserted between edges.
        @(negedge clk);
        dividend = 16'hFFFF; divisor = 8'hFF; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst finished", finished, 1'b0);
        chk("rst quotient", quotient, 16'h0);
        chk("rst remainder", remainder, 8'h0);
        chk("rst div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            repeat (20) begin @(negedge clk); if (finished) seen++; end
            chk("rst no_partial_result", seen, 0);
        end
        run_vec(vecs[1], 16'h0000, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
